// File: rtl/jt5205_pkg.sv
// Shared MSM5205 ADPCM tables and encoder FSM encoding, imported by the encoder and the decoder.
package jt5205_pkg;

  localparam int STEP_MAX = 48;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUB  = 3'd1,
    ST_B2   = 3'd2,
    ST_B1   = 3'd3,
    ST_B0   = 3'd4,
    ST_UPD  = 3'd5
  } enc_state_e;

  localparam logic [10:0] STEP_TAB [0:48] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  // Index adjustment by magnitude bits {b2,b1,b0}.
  localparam logic signed [4:0] IDX_ADJ [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  function automatic logic signed [11:0] sat12(input logic signed [13:0] v);
    if (v > 14'sd2047)       return 12'sh7ff;
    else if (v < -14'sd2048) return 12'sh800;
    else                     return v[11:0];
  endfunction

endpackage

// File: rtl/jt5205_enc_if.sv
// PCM input stream and ADPCM nibble output of the jt5205 encoder.
interface jt5205_enc_if;
  // pcm is taken on a clk where pcm_valid and pcm_ready are both high; pcm_valid
  // may not depend on pcm_ready. dout is qualified by the 1-clk dout_valid strobe.
  logic [11:0] pcm;
  logic        pcm_valid;
  logic        pcm_ready;
  logic [3:0]  dout;
  logic        dout_valid;

  modport master (output pcm, pcm_valid, input pcm_ready, dout, dout_valid);
  modport slave  (input pcm, pcm_valid, output pcm_ready, dout, dout_valid);
endinterface

// File: rtl/jt5205_enc_tick.sv
// Sample-rate divider: counts cen pulses and strobes tick on the cen that wraps 96/64/48.
module jt5205_enc_tick (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic [1:0] sel,
  output logic       tick
);

  logic [6:0] cnt;
  logic [6:0] base;
  logic [6:0] nxt;
  logic [6:0] period;
  logic [1:0] sel_l;
  logic       chg;

  always_comb begin
    case (sel)
      2'b00:   period = 7'd96;
      2'b01:   period = 7'd64;
      2'b10:   period = 7'd48;
      default: period = 7'd0;
    endcase
    // A new rate selection counts its first cen from zero.
    chg  = (sel != sel_l);
    base = chg ? 7'd0 : cnt;
    nxt  = base + 7'd1;
    tick = cen && (sel != 2'b11) && (nxt == period);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 7'd0;
      sel_l <= 2'b00;
    end else if (cen) begin
      sel_l <= sel;
      if (sel == 2'b11) cnt <= base;
      else              cnt <= tick ? 7'd0 : nxt;
    end
  end

endmodule

// File: rtl/jt5205_enc.sv
// MSM5205-compatible ADPCM encoder: 12-bit PCM in, OKI nibbles out at the S-pin rate.
// JT5205_ENC_RECON_EN adds the recon[11:0] port carrying the post-update predictor.
module jt5205_enc #(
  parameter int STEP_MAX = jt5205_pkg::STEP_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic [1:0]             sel,
  jt5205_enc_if.slave            bus,
  output logic                   underrun,
`ifdef JT5205_ENC_RECON_EN
  output logic [11:0]            recon,
`endif
  output jt5205_pkg::enc_state_e state
);

  import jt5205_pkg::*;

  logic tick;

  jt5205_enc_tick u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .sel   (sel),
    .tick  (tick)
  );

  logic               buf_full;
  logic [11:0]        buf_pcm;
  logic [11:0]        last;
  logic [11:0]        smp;
  logic signed [11:0] pred;
  logic [5:0]         idx;
  logic               sign;
  logic [12:0]        mag;
  logic [2:0]         code;
  logic [11:0]        acc;

  logic [10:0]        step;
  logic [12:0]        trial;
  logic               hit;
  logic [12:0]        mag_left;
  logic signed [12:0] diff;
  logic [12:0]        mag_abs;
  logic [11:0]        delta;
  logic signed [13:0] sum;
  logic signed [11:0] pred_nxt;
  logic signed [4:0]  adj;
  logic signed [7:0]  isum;
  logic [5:0]         idx_nxt;
  logic               wr;

  assign step          = STEP_TAB[idx];
  assign wr            = bus.pcm_valid & ~buf_full;
  assign bus.pcm_ready = ~buf_full;

  always_comb begin
    case (state)
      ST_B1:   trial = {3'b000, step[10:1]};
      ST_B0:   trial = {4'b0000, step[10:2]};
      default: trial = {2'b00, step};
    endcase
    hit      = (mag >= trial);
    mag_left = mag - trial;

    diff    = $signed({smp[11], smp}) - $signed({pred[11], pred});
    mag_abs = diff[12] ? 13'(-diff) : 13'(diff);

    // acc already holds step>>3 plus the b2/b1 terms; b0 is decided this cycle.
    delta    = acc + (hit ? trial[11:0] : 12'd0);
    sum      = sign ? ($signed({{2{pred[11]}}, pred}) - $signed({2'b00, delta}))
                    : ($signed({{2{pred[11]}}, pred}) + $signed({2'b00, delta}));
    pred_nxt = sat12(sum);

    adj  = IDX_ADJ[code];
    isum = $signed({2'b00, idx}) + $signed({{3{adj[4]}}, adj});
    if (isum[7])                         idx_nxt = 6'd0;
    else if (isum[6:0] > 7'(STEP_MAX))   idx_nxt = 6'(STEP_MAX);
    else                                 idx_nxt = isum[5:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      buf_full       <= 1'b0;
      buf_pcm        <= 12'd0;
      last           <= 12'd0;
      smp            <= 12'd0;
      pred           <= 12'sd0;
      idx            <= 6'd0;
      sign           <= 1'b0;
      mag            <= 13'd0;
      code           <= 3'd0;
      acc            <= 12'd0;
      bus.dout       <= 4'd0;
      bus.dout_valid <= 1'b0;
      underrun       <= 1'b0;
`ifdef JT5205_ENC_RECON_EN
      recon          <= 12'd0;
`endif
    end else begin
      bus.dout_valid <= 1'b0;
      // A write in the tick cycle lands after the tick has looked at the buffer.
      if (wr) begin
        buf_full <= 1'b1;
        buf_pcm  <= bus.pcm;
      end
      case (state)
        ST_IDLE: begin
          if (tick) begin
            if (buf_full) begin
              smp      <= buf_pcm;
              last     <= buf_pcm;
              buf_full <= 1'b0;
            end else begin
              smp      <= last;
              underrun <= 1'b1;
            end
            state <= ST_SUB;
          end
        end
        ST_SUB: begin
          sign  <= diff[12];
          mag   <= mag_abs;
          acc   <= {4'b0000, step[10:3]};
          code  <= 3'd0;
          state <= ST_B2;
        end
        ST_B2: begin
          if (hit) begin
            code[2] <= 1'b1;
            mag     <= mag_left;
            acc     <= acc + trial[11:0];
          end
          state <= ST_B1;
        end
        ST_B1: begin
          if (hit) begin
            code[1] <= 1'b1;
            mag     <= mag_left;
            acc     <= acc + trial[11:0];
          end
          state <= ST_B0;
        end
        ST_B0: begin
          code[0]        <= hit;
          pred           <= pred_nxt;
          bus.dout       <= {sign, code[2:1], hit};
          bus.dout_valid <= 1'b1;
`ifdef JT5205_ENC_RECON_EN
          recon          <= pred_nxt;
`endif
          state          <= ST_UPD;
        end
        ST_UPD: begin
          idx   <= idx_nxt;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt5205_enc.sv
// Scoreboard bench for jt5205_enc: expected nibbles queued at acceptance, popped on dout_valid.
module tb_jt5205_enc;

  logic       clk;
  logic       rst_n;
  logic       cen;
  logic [1:0] sel;
  logic       underrun;
  jt5205_pkg::enc_state_e state;
`ifdef JT5205_ENC_RECON_EN
  logic [11:0] recon;
`endif

  jt5205_enc_if bus ();

  jt5205_enc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .sel      (sel),
    .bus      (bus),
    .underrun (underrun),
`ifdef JT5205_ENC_RECON_EN
    .recon    (recon),
`endif
    .state    (state)
  );

  // ---------------- clock / cen / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cen = 1'b0;
    forever begin
      @(posedge clk);
      #1 cen = ~cen;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int cen_cnt  = 0;
  int last_cen = 0;
  int gap      = 0;
  logic [15:0] exp_q[$];

  int step_tab[49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73,
                       80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279,
                       307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
                       1060, 1166, 1282, 1411, 1552};
  int m_pred, m_idx, m_last;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic void model_reset();
    m_pred = 0;
    m_idx  = 0;
    m_last = 0;
  endfunction

  // Reference OKI encoder followed by the standard decoder update.
  function automatic int model_enc(input int s);
    int st, d, code, dq;
    st   = step_tab[m_idx];
    d    = s - m_pred;
    code = 0;
    if (d < 0) begin code = 8; d = -d; end
    if (d >= st)     begin code += 4; d -= st; end
    if (d >= st / 2) begin code += 2; d -= st / 2; end
    if (d >= st / 4) code += 1;
    dq = st / 8;
    if ((code & 4) != 0) dq += st;
    if ((code & 2) != 0) dq += st / 2;
    if ((code & 1) != 0) dq += st / 4;
    if (code >= 8) m_pred -= dq;
    else           m_pred += dq;
    if (m_pred > 2047)  m_pred = 2047;
    if (m_pred < -2048) m_pred = -2048;
    if ((code & 4) == 0) m_idx -= 1;
    else                 m_idx += 2 * (code & 3) + 2;
    if (m_idx < 0)  m_idx = 0;
    if (m_idx > 48) m_idx = 48;
    m_last = s;
    return code;
  endfunction

  function automatic void push_exp(input int nib);
    exp_q.push_back({12'(m_pred), 4'(nib)});
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (cen) cen_cnt++;
      if (bus.dout_valid) begin
        n_out++;
        gap      = cen_cnt - last_cen;
        last_cen = cen_cnt;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_dout: got %0d with nothing expected (t=%0t)",
                   bus.dout, $time);
        end else begin
          e = exp_q.pop_front();
          check("dout", int'(bus.dout), int'(e[3:0]));
`ifdef JT5205_ENC_RECON_EN
          check("recon", int'($signed(recon)), int'($signed(e[15:4])));
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // hand >= 0 overrides the model nibble with a hand-computed value.
  task automatic send(input int v, input int hand);
    int nib, n;
    @(posedge clk);
    #1;
    bus.pcm       = 12'(v);
    bus.pcm_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.pcm_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pcm_ready) timeout("send_accept");
    @(posedge clk);
    #1 bus.pcm_valid = 1'b0;
    nib = model_enc(v);
    if (hand >= 0) nib = hand;
    push_exp(nib);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout("drain");
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  int zero_nib[8] = '{0, 8, 0, 8, 0, 8, 0, 8};

  initial begin
    int k, n0, early, n, dvs;
    rst_n         = 1'b0;
    sel           = 2'b10;
    bus.pcm       = 12'd0;
    bus.pcm_valid = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(bus.pcm_ready), 1);
    check("rst_dout_valid", int'(bus.dout_valid), 0);
    check("rst_dout", int'(bus.dout), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_state", int'(state), int'(jt5205_pkg::ST_IDLE));
`ifdef JT5205_ENC_RECON_EN
    check("rst_recon", int'(recon), 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Silence at /48: alternating 0/8 nibbles.
    for (int i = 0; i < 8; i++) send(0, zero_nib[i]);
    wait_drain();
    check("tick_gap_cen", gap, 48);
    check("no_underrun_fed", int'(underrun), 0);

    // Stopped divider, then /64 start-up latency.
    @(posedge clk);
    #1 sel = 2'b11;
    n0 = n_out;
    k  = 0;
    while (k < 1000) begin
      @(negedge clk);
      if (cen) k++;
    end
    check("stopped_outputs", n_out - n0, 0);
    send(100, -1);
    @(posedge clk);
    #1 sel = 2'b01;
    k     = 0;
    early = 0;
    while (k < 64) begin
      @(negedge clk);
      if (cen) k++;
      if (bus.dout_valid) early++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.dout_valid) early++;
    end
    @(negedge clk);
    check("latency_early_dv", early, 0);
    check("latency_dv_at_5", int'(bus.dout_valid), 1);
    wait_drain();

    // Backpressure with a full buffer, then an underrun.
    @(posedge clk);
    #1 sel = 2'b10;
    send(500, -1);
    bus.pcm       = 12'(-700);
    bus.pcm_valid = 1'b1;
    @(negedge clk);
    check("ready_falls", int'(bus.pcm_ready), 0);
    n = 0;
    while (!bus.pcm_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("bp_ready_after_tick", int'(bus.pcm_ready), 1);
    check("bp_state_sub", int'(state), int'(jt5205_pkg::ST_SUB));
    @(posedge clk);
    #1 bus.pcm_valid = 1'b0;
    push_exp(model_enc(-700));
    wait_drain();
    check("underrun_before", int'(underrun), 0);
    push_exp(model_enc(m_last));
    wait_drain();
    check("underrun_after", int'(underrun), 1);

    // Reset during B1 aborts the encode.
    send(300, -1);
    n = 0;
    @(negedge clk);
    while (state != jt5205_pkg::ST_B1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reached_b1", int'(state), int'(jt5205_pkg::ST_B1));
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    model_reset();
    dvs = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.dout_valid) dvs++;
    end
    check("abort_no_dv", dvs, 0);
    check("abort_state", int'(state), int'(jt5205_pkg::ST_IDLE));
    check("abort_underrun", int'(underrun), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(300, 7);
    wait_drain();

    // Full-scale positive input: predictor climbs to 2047 and holds.
    reset_pulse();
    send(2047, 7);
    for (int i = 0; i < 39; i++) send(2047, -1);
    wait_drain();

    // Full-scale negative input.
    reset_pulse();
    send(-2048, 15);
    for (int i = 0; i < 39; i++) send(-2048, -1);
    wait_drain();

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
